// File: rtl/serial_recv.sv
// serial_recv: 8N1 UART receive engine (2-flop synchronizer, mid-bit sampling).
// Define SERIAL_RECV_MAJORITY_EN to sample with a 2-of-3 majority of the synchronized line.
module serial_recv #(
   parameter int DIVISOR = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       framing_error,
   output logic       busy,
   output logic [2:0] state_o
);
   localparam int CW = $clog2(DIVISOR);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(DIVISOR - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          sync1_q;
   logic          rx_s;
   logic          samp;

`ifdef SERIAL_RECV_MAJORITY_EN
   // hist_q[0] doubles as the second synchronizer stage, so rx_s is hist_q[0].
   logic [2:0] hist_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         hist_q  <= 3'b111;
      end else begin
         sync1_q <= rxd;
         hist_q  <= {hist_q[1:0], sync1_q};
      end
   end

   assign rx_s = hist_q[0];
   assign samp = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
   logic sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;
   assign samp = sync2_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   // Start sample lands half a bit after the edge; every later sample is one full bit on.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            count_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (count_q == HALF_M1) begin
               count_d   = '0;
               bit_idx_d = '0;
               state_d   = samp ? S_IDLE : S_DATA;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         S_DATA: begin
            if (count_q == FULL_M1) begin
               count_d   = '0;
               shift_d   = {samp, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         S_STOP: begin
            if (count_q == FULL_M1) begin
               count_d = '0;
               if (samp) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign data          = data_q;
   assign data_valid    = valid_q;
   assign framing_error = ferr_q;
   assign busy          = (state_q != S_IDLE);
   assign state_o       = state_q;
endmodule

// File: tb/tb_serial_recv.sv
// tb_serial_recv: waveform-level reference model for two serial_recv instances (DIVISOR 16 and 868).
// Expected outputs are derived from sample-point arithmetic on the prebuilt rxd waveform.
`timescale 1ns/1ps
module tb_serial_recv;
   localparam int D0   = 16;
   localparam int D1   = 868;
   localparam int NMAX = 24000;

   // ---------------- clock / reset / DUTs ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset0, rxd0, reset1, rxd1;
   logic [7:0] data0, data1;
   logic       dv0, dv1, fe0, fe1, busy0, busy1;
   logic [2:0] st0, st1;

   serial_recv #(.DIVISOR(D0)) dut16 (
      .clk(clk), .reset(reset0), .rxd(rxd0), .data(data0), .data_valid(dv0),
      .framing_error(fe0), .busy(busy0), .state_o(st0)
   );
   serial_recv #(.DIVISOR(D1)) dut868 (
      .clk(clk), .reset(reset1), .rxd(rxd1), .data(data1), .data_valid(dv1),
      .framing_error(fe1), .busy(busy1), .state_o(st1)
   );

   // ---------------- waveform and model storage ----------------
   logic       wave   [2][NMAX];
   logic       rstw   [2][NMAX];
   int         wl     [2];
   logic       rsa    [2][NMAX];
   logic [2:0] hist   [2][NMAX];
   logic [7:0] e_data [2][NMAX];
   logic       e_dv   [2][NMAX];
   logic       e_fe   [2][NMAX];
   logic       e_busy [2][NMAX];

   int         n_cmp = 0;
   int         n_fail = 0;
   int         cur_n = 0;
   int         cnt_v [2];
   int         cnt_e [2];
   logic [7:0] rxlog [$];

   // ---------------- stimulus builders ----------------
   task automatic put(input int k, input logic v, input int len);
      for (int i = 0; i < len; i++) begin
         wave[k][wl[k]] = v;
         wl[k]++;
      end
   endtask

   // num/den stretches the sender's bit period relative to the receiver's DIVISOR.
   task automatic put_frame(input int k, input logic [7:0] b, input logic stop,
                            input int d, input int num, input int den);
      logic v;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) v = 1'b0;
         else if (i == 9) v = stop;
         else v = b[i-1];
         put(k, v, ((i + 1) * d * num) / den - (i * d * num) / den);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic samp_at(input int k, input int p);
`ifdef SERIAL_RECV_MAJORITY_EN
      int ones;
      ones = 0;
      for (int j = 0; j < 3; j++) if (hist[k][p-1][j]) ones++;
      return (ones >= 2);
`else
      return rsa[k][p-1];
`endif
   endfunction

   function automatic int first_rst(input int k, input int a, input int b);
      for (int n = a + 1; n <= b; n++) if (rstw[k][n]) return n;
      return 0;
   endfunction

   task automatic fill(input int k, input int a, input int b, input logic bz, input logic [7:0] dt);
      for (int n = a; n <= b && n < NMAX; n++) begin
         e_busy[k][n] = bz;
         e_dv[k][n]   = 1'b0;
         e_fe[k][n]   = 1'b0;
         e_data[k][n] = dt;
      end
   endtask

   task automatic build_model(input int k, input int d);
      logic       s1p;
      logic [7:0] cur, byt;
      int         p, m, ts, te, r, q;
      s1p = 1'b1;
      rsa[k][0]  = 1'b1;
      hist[k][0] = 3'b111;
      for (int n = 1; n < NMAX; n++) begin
         if (rstw[k][n]) begin
            rsa[k][n]  = 1'b1;
            hist[k][n] = 3'b111;
            s1p        = 1'b1;
         end else begin
            rsa[k][n]  = s1p;
            hist[k][n] = {hist[k][n-1][1:0], s1p};
            s1p        = wave[k][n];
         end
      end
      cur = 8'h00;
      byt = 8'h00;
      p   = 1;
      while (p < NMAX) begin
         if (rstw[k][p]) begin
            cur = 8'h00;
            fill(k, p, p, 1'b0, cur);
            p++;
         end else if (rsa[k][p-1]) begin
            fill(k, p, p, 1'b0, cur);
            p++;
         end else begin
            m  = p;
            ts = m + d / 2;
            te = ts + 9 * d;
            if (te >= NMAX) begin
               fill(k, m, NMAX - 1, 1'b1, cur);
               p = NMAX;
            end else begin
               r = first_rst(k, m, te);
               if (r != 0 && r <= ts) begin
                  fill(k, m, r - 1, 1'b1, cur);
                  p = r;
               end else if (samp_at(k, ts)) begin
                  fill(k, m, ts - 1, 1'b1, cur);
                  fill(k, ts, ts, 1'b0, cur);
                  p = ts + 1;
               end else if (r != 0) begin
                  fill(k, m, r - 1, 1'b1, cur);
                  p = r;
               end else begin
                  for (int i = 0; i < 8; i++) byt[i] = samp_at(k, ts + (i + 1) * d);
                  fill(k, m, te - 1, 1'b1, cur);
                  if (samp_at(k, te)) begin
                     cur = byt;
                     fill(k, te, te, 1'b0, cur);
                     e_dv[k][te] = 1'b1;
                     p = te + 1;
                  end else begin
                     fill(k, te, te, 1'b1, cur);
                     e_fe[k][te] = 1'b1;
                     q = te + 1;
                     while (q < NMAX && !rstw[k][q] && !rsa[k][q-1]) begin
                        fill(k, q, q, 1'b1, cur);
                        q++;
                     end
                     if (q < NMAX && !rstw[k][q]) begin
                        fill(k, q, q, 1'b0, cur);
                        q++;
                     end
                     p = q;
                  end
               end
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input int k, input int n, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, n, got, exp);
      end
   endtask

   task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic cmp_cycle(input int k, input int n, input logic dv, input logic fe,
                            input logic bz, input logic [7:0] dt);
      chk("data_valid", k, n, {7'b0, dv}, {7'b0, e_dv[k][n]});
      chk("framing_error", k, n, {7'b0, fe}, {7'b0, e_fe[k][n]});
      chk("busy", k, n, {7'b0, bz}, {7'b0, e_busy[k][n]});
      chk("data", k, n, dt, e_data[k][n]);
      if (dv === 1'b1) begin
         cnt_v[k]++;
         if (k == 0) rxlog.push_back(dt);
      end
      if (fe === 1'b1) cnt_e[k]++;
   endtask

   always @(negedge clk) begin
      if (cur_n >= 1) begin
         cmp_cycle(0, cur_n, dv0, fe0, busy0, data0);
         cmp_cycle(1, cur_n, dv1, fe1, busy1, data1);
      end
   end

   // ---------------- driver ----------------
   int         nc;
   int         fa, ma, fb, mb, mc, mc2, fd, rr, fend, md, me, m1a, m1b;
   logic [7:0] exp_e, rb;

   initial begin
      cnt_v[0] = 0; cnt_v[1] = 0; cnt_e[0] = 0; cnt_e[1] = 0;
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < NMAX; n++) begin
            wave[k][n] = 1'b1;
            rstw[k][n] = 1'b0;
         end
         wl[k] = 1;
         for (int n = 1; n <= 3; n++) rstw[k][n] = 1'b1;
         put(k, 1'b1, 23);
      end

      // DIVISOR=16: back-to-back 0x55, 0xA3
      fa = wl[0];
      put_frame(0, 8'h55, 1'b1, D0, 1, 1);
      put_frame(0, 8'hA3, 1'b1, D0, 1, 1);
      put(0, 1'b1, 40);
      ma = wl[0];
      // short low glitch
      fb = wl[0];
      put(0, 1'b0, 5);
      put(0, 1'b1, 40);
      mb = wl[0];
      // bad stop, held break, then a good frame
      put_frame(0, 8'h3C, 1'b0, D0, 1, 1);
      put(0, 1'b0, 100);
      put(0, 1'b1, 40);
      mc = wl[0];
      put_frame(0, 8'h7E, 1'b1, D0, 1, 1);
      put(0, 1'b1, 40);
      mc2 = wl[0];
      // reset pulse in the middle of data bit 4 of 0x81
      fd = wl[0];
      put_frame(0, 8'h81, 1'b1, D0, 1, 1);
      rr = fd + 5 * D0 + D0 / 2;
      rstw[0][rr] = 1'b1;
      fend = wl[0];
      put(0, 1'b1, 12 * D0);
      put_frame(0, 8'h42, 1'b1, D0, 1, 1);
      put(0, 1'b1, 40);
      md = wl[0];
      // 0x00 with a one-cycle high glitch centred on the bit-3 sample
      rb = wl[0];
      put_frame(0, 8'h00, 1'b1, D0, 1, 1);
      wave[0][wl[0] - 10 * D0 + 4 * D0 + D0 / 2] = 1'b1;
      put(0, 1'b1, 40);
      me = wl[0];
`ifdef SERIAL_RECV_MAJORITY_EN
      exp_e = 8'h00;
`else
      exp_e = 8'h08;
`endif
      // randomized frames: random data, gaps, sender rate and occasional bad stop
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            put_frame(0, 8'($urandom_range(0, 255)), 1'b0, D0, $urandom_range(97, 103), 100);
            put(0, 1'b0, $urandom_range(0, 30));
            put(0, 1'b1, $urandom_range(20, 40));
         end else begin
            put_frame(0, 8'($urandom_range(0, 255)), 1'b1, D0, $urandom_range(97, 103), 100);
            put(0, 1'b1, $urandom_range(0, 20));
         end
      end
      put(0, 1'b1, 60);

      // DIVISOR=868: 0xC6 with a 4% slow sender, then a 4% fast sender
      put_frame(1, 8'hC6, 1'b1, D1, 104, 100);
      put(1, 1'b1, 1000);
      m1a = wl[1];
      put_frame(1, 8'hC6, 1'b1, D1, 96, 100);
      put(1, 1'b1, 1000);
      m1b = wl[1];

      build_model(0, D0);
      build_model(1, D1);
      nc = ((wl[0] > wl[1]) ? wl[0] : wl[1]) + 20;

      reset0 = 1'b1; rxd0 = 1'b1; reset1 = 1'b1; rxd1 = 1'b1;
      for (int n = 1; n < nc; n++) begin
         reset0 = rstw[0][n]; rxd0 = wave[0][n];
         reset1 = rstw[1][n]; rxd1 = wave[1][n];
         @(posedge clk);
         #1;
         cur_n = n;
         if (n == 3) begin
            lit("reset_data", data0, 8'h00);
            lit("reset_valid", {7'b0, dv0}, 8'h00);
            lit("reset_busy", {7'b0, busy0}, 8'h00);
            lit("reset_state", {5'b0, st0}, 8'h00);
         end
         if (n == fa + 1) lit("busy_before_start", {7'b0, busy0}, 8'h00);
         if (n == fa + 2) lit("busy_at_start", {7'b0, busy0}, 8'h01);
         if (n == fa + 153) lit("valid_early", {7'b0, dv0}, 8'h00);
         if (n == fa + 154) begin
            lit("valid_at_latency", {7'b0, dv0}, 8'h01);
            lit("data_first", data0, 8'h55);
         end
         if (n == fa + 155) lit("valid_one_cycle", {7'b0, dv0}, 8'h00);
         if (n == ma) begin
            lit("a_count", 8'(cnt_v[0]), 8'd2);
            lit("a_errors", 8'(cnt_e[0]), 8'd0);
            lit("a_log0", (rxlog.size() > 0) ? rxlog[0] : 8'hxx, 8'h55);
            lit("a_log1", (rxlog.size() > 1) ? rxlog[1] : 8'hxx, 8'hA3);
         end
         if (n == fb + 4) lit("glitch_busy", {7'b0, busy0}, 8'h01);
         if (n == mb) begin
            lit("glitch_count", 8'(cnt_v[0]), 8'd2);
            lit("glitch_errors", 8'(cnt_e[0]), 8'd0);
            lit("glitch_data", data0, 8'hA3);
            lit("glitch_state", {5'b0, st0}, 8'h00);
         end
         if (n == mc) begin
            lit("break_errors", 8'(cnt_e[0]), 8'd1);
            lit("break_data", data0, 8'hA3);
            lit("break_busy", {7'b0, busy0}, 8'h00);
         end
         if (n == mc2) lit("after_break_data", data0, 8'h7E);
         if (n == rr) begin
            lit("midreset_data", data0, 8'h00);
            lit("midreset_busy", {7'b0, busy0}, 8'h00);
            lit("midreset_valid", {7'b0, dv0}, 8'h00);
            lit("midreset_ferr", {7'b0, fe0}, 8'h00);
         end
         if (n == fend) begin
            lit("midreset_no_valid", 8'(cnt_v[0]), 8'd3);
            lit("midreset_no_ferr", 8'(cnt_e[0]), 8'd1);
         end
         if (n == md) lit("after_reset_data", data0, 8'h42);
         if (n == me) lit("bit3_glitch_data", data0, exp_e);
         if (n == rb + 2) lit("bit3_frame_busy", {7'b0, busy0}, 8'h01);
         if (n == m1a) begin
            lit("slow_data", data1, 8'hC6);
            lit("slow_count", 8'(cnt_v[1]), 8'd1);
            lit("slow_errors", 8'(cnt_e[1]), 8'd0);
         end
         if (n == m1b) begin
            lit("fast_data", data1, 8'hC6);
            lit("fast_count", 8'(cnt_v[1]), 8'd2);
            lit("fast_errors", 8'(cnt_e[1]), 8'd0);
         end
      end
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_recv.md
# serial_recv

UART receive engine, the inbound counterpart of the team's 8N1 serial transmitter. It samples an asynchronous RS232 line, reassembles 8-bit characters, and hands each one to downstream logic as a single-cycle strobe. It sits between the board's RS232 receiver pin and the command/ASCII parsing logic. Framing (1 start bit, 8 data bits LSB first, 1 stop bit, idle mark = 1) and default rate (115,200 baud, 868 clocks per bit) match the transmitter.

## Interface
- DIVISOR, 868, clocks per bit period; legal range 4..65535. The counter is $clog2(DIVISOR) bits wide.
- clk  input  1  system clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  raw asynchronous serial line; idle = 1.
- data  output  8  last correctly framed character; holds until the next good frame.
- data_valid  output  1  one-cycle pulse; `data` is new in the same cycle.
- framing_error  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

## Operation
- Synchronizer: `rxd` passes through two flops, giving rx_s. Both flops reset to 1. All decisions use rx_s only.
- Sample value `s`: equals rx_s, or the majority vote when the majority-vote feature is enabled (see Configuration).
- State IDLE: count = 0. If rx_s == 0, go to START.
- State START: count increments each cycle. At count == DIVISOR/2−1 (integer divide), take sample `s`:
  - `s` == 0: go to DATA, clear count and the bit index.
  - `s` == 1: treat as a glitch and return to IDLE with no output.
- State DATA: at count == DIVISOR−1, shift `s` into the shift register MSB (LSB arrives first), clear count, and increment the bit index. After the 8th bit, go to STOP.
- State STOP: at count == DIVISOR−1, take sample `s`:
  - `s` == 1: load `data` from the shift register, pulse data_valid, and go to IDLE.
  - `s` == 0: pulse framing_error, leave `data` unchanged, and go to BREAK.
- State BREAK: wait until rx_s == 1, then go to IDLE. A held-low line (break) therefore yields exactly one framing_error and no further frames.
- data_valid and framing_error are never high in the same cycle. Each is asserted for exactly one cycle per frame.
- Reset values: state IDLE, count 0, data 8'h00, data_valid 0, framing_error 0, busy 0, shift register 0.
- Reset asserted mid-frame: the frame is abandoned, with no pulse on either strobe. After release the block re-arms on the next low rx_s.

## Timing
- Edge to START: rxd falls at cycle 0. rx_s is low at cycle 2, and state is START at cycle 3.
- Sample points: the start-bit sample is taken DIVISOR/2 cycles after entering START. Each later sample follows the previous one by exactly DIVISOR cycles, so every sample lands at mid-bit.
- Output latency: data_valid rises 1 cycle after the stop-bit sample. That is about 3 + DIVISOR/2 + 9·DIVISOR cycles after the start edge.
- Back-to-back frames: after the stop sample the block is in IDLE about DIVISOR/2 cycles before the next start edge. Frames with a single stop bit and no idle gap are received without loss.
- Baud tolerance: a total clock mismatch of up to ±4% between the two ends must still decode correctly.
- busy rises with the entry to START and falls the cycle the state returns to IDLE.

## Configuration
- SERIAL_RECV_MAJORITY_EN defined:
  - The block keeps a 3-bit history of rx_s.
  - Every sample point (start, data, stop) uses the 2-of-3 majority of rx_s from the current and two previous cycles.
  - A single-cycle glitch at a sample point is rejected.
  - The history register resets to 3'b111.
- Undefined: each sample point uses rx_s directly, and the history register is not built. Sample timing is identical in both builds.

## Test plan
- DIVISOR=16, send 0x55 then 0xA3, with ideal timing and 1 stop bit and no gap:
  - data_valid pulses twice; data = 0x55, then 0xA3; framing_error stays 0.
- Drive rxd low for 5 cycles, then high:
  - busy pulses; data_valid and framing_error never assert; state returns to IDLE; data is unchanged.
- Send 0x3C with a stop bit of 0, then hold rxd low for 100 cycles, then release:
  - exactly one framing_error pulse; data keeps its previous value.
  - A subsequent 0x7E then decodes correctly.
- Assert reset for 1 cycle during data bit 4 of 0x81:
  - no strobe; outputs return to reset values.
  - A following 0x42 yields data = 0x42.
- With SERIAL_RECV_MAJORITY_EN defined, send 0x00 with a 1-cycle high glitch centred on the bit-3 sample point:
  - data = 0x00.
  - Without the macro the same stimulus gives 0x08.
- DIVISOR=868, send 0xC6 with the sender's bit period 4% longer, then 4% shorter:
  - data = 0xC6 both times; no framing_error.
